pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the MIPS-style core; the next-generation PC unit.
- Each cycle it selects the next fetch address from: sequential (PC+4), taken branch, J-type jump, register jump, exception vector, or exception return.
- Adds stall support, buffering of redirects that arrive during a stall, and EPC/exception-level tracking.
- Sits between the branch/jump resolution logic and instruction memory.

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus between the branch/jump resolution logic and the PC sequencer.
// When PC_ALIGN_CHECK_EN is defined, the bus also carries the misalign pulse.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             pc_wr;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jump;
    logic [25:0]      jump_idx;
    logic             jr;
    logic [WIDTH-1:0] jr_target;
    logic             exc;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             exl;
    logic             redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign;
`endif

    modport master (
        output pc_wr, br_taken, br_target, jump, jump_idx, jr, jr_target, exc, eret,
        input  pc, pc_plus4, epc, exl, redirect_pending
`ifdef PC_ALIGN_CHECK_EN
        , input misalign
`endif
    );

    modport slave (
        input  pc_wr, br_taken, br_target, jump, jump_idx, jr, jr_target, exc, eret,
        output pc, pc_plus4, epc, exl, redirect_pending
`ifdef PC_ALIGN_CHECK_EN
        , output misalign
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next fetch address selection with stall, redirect buffering and EPC/EXL.
// Optional PC_ALIGN_CHECK_EN turns misaligned redirect targets into exceptions and drives misalign.
//
// state     | meaning
// HOLD_NONE | no buffered redirect; requests apply directly when pc_wr=1
// HOLD_PEND | a redirect arrived during a stall and waits for pc_wr=1
module pc_sequencer #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);
    typedef enum logic {
        HOLD_NONE = 1'b0,
        HOLD_PEND = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] LOW28  = WIDTH'(28'hFFF_FFFF);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             exl_q, exl_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_eret_q, pend_eret_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] jump_tgt;
    logic             req;
    logic [WIDTH-1:0] req_tgt;
    logic             apply_en;
    logic [WIDTH-1:0] apply_tgt;
    logic             apply_eret;

    assign pc_plus4 = pc_q + WIDTH'(4);
    // Upper bits come from the delay-slot PC, low 28 from the instruction index.
    assign jump_tgt = (pc_plus4 & ~LOW28) | WIDTH'({bus.jump_idx, 2'b00});

    assign req = bus.eret | bus.jr | bus.br_taken | bus.jump;

    always_comb begin
        req_tgt = jump_tgt;
        if (bus.eret)          req_tgt = epc_q;
        else if (bus.jr)       req_tgt = bus.jr_target;
        else if (bus.br_taken) req_tgt = bus.br_target;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        exl_d       = exl_q;
        pend_tgt_d  = pend_tgt_q;
        pend_eret_d = pend_eret_q;
        mis_d       = 1'b0;
        apply_en    = 1'b0;
        apply_tgt   = req_tgt;
        apply_eret  = bus.eret;

        if (bus.exc) begin
            pc_d    = EXC_PC;
            state_d = HOLD_NONE;
            if (!exl_q) begin
                epc_d = pc_q;
                exl_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                HOLD_NONE: begin
                    if (bus.pc_wr) begin
                        if (req) apply_en = 1'b1;
                        else     pc_d     = pc_plus4;
                    end else if (req) begin
                        pend_tgt_d  = req_tgt;
                        pend_eret_d = bus.eret;
                        state_d     = HOLD_PEND;
                    end
                end
                HOLD_PEND: begin
                    // New requests are dropped: the older instruction's redirect wins.
                    if (bus.pc_wr) begin
                        apply_en   = 1'b1;
                        apply_tgt  = pend_tgt_q;
                        apply_eret = pend_eret_q;
                        state_d    = HOLD_NONE;
                    end
                end
                default: state_d = HOLD_NONE;
            endcase

            if (apply_en) begin
`ifdef PC_ALIGN_CHECK_EN
                if (apply_tgt[1:0] != 2'b00) begin
                    pc_d  = EXC_PC;
                    mis_d = 1'b1;
                    if (!exl_q) begin
                        epc_d = apply_tgt;
                        exl_d = 1'b1;
                    end
                end else begin
                    pc_d = apply_tgt;
                    if (apply_eret) exl_d = 1'b0;
                end
`else
                pc_d = apply_tgt;
                if (apply_eret) exl_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOLD_NONE;
            pc_q        <= RST_PC;
            epc_q       <= '0;
            exl_q       <= 1'b0;
            pend_tgt_q  <= '0;
            pend_eret_q <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            exl_q       <= exl_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_eret_q <= pend_eret_d;
            mis_q       <= mis_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_plus4;
    assign bus.epc              = epc_q;
    assign bus.exl              = exl_q;
    assign bus.redirect_pending = (state_q == HOLD_PEND);
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign         = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes expected state per cycle, popped after the edge.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam logic [31:0] RST_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(32)) bus ();
    pc_sequencer #(.WIDTH(32), .RESET_VEC(RST_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        exl;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc, m_ptgt;
    logic        m_exl, m_pend, m_peret, m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_apply(input logic [31:0] t, input logic is_eret);
`ifdef PC_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            m_mis = 1'b1;
            if (!m_exl) begin
                m_epc = t;
                m_exl = 1'b1;
            end
            m_pc = EXC_VEC;
            return;
        end
`endif
        m_pc = t;
        if (is_eret) m_exl = 1'b0;
    endtask

    task automatic cyc(input logic rs, input logic wr, input logic brt, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji, input logic r, input logic [31:0] rt,
                       input logic e, input logic er);
        logic [31:0] pp4, jt, tgt;
        logic        req;
        exp_t        x;
        exp_t        got;
        @(negedge clk);
        rst = rs; bus.pc_wr = wr; bus.br_taken = brt; bus.br_target = bt;
        bus.jump = j; bus.jump_idx = ji; bus.jr = r; bus.jr_target = rt;
        bus.exc = e; bus.eret = er;

        m_mis = 1'b0;
        pp4 = m_pc + 32'd4;
        jt  = {pp4[31:28], ji, 2'b00};
        req = er | r | brt | j;
        tgt = er ? m_epc : r ? rt : brt ? bt : jt;
        if (rs) begin
            m_pc = RST_VEC; m_epc = '0; m_exl = 1'b0; m_pend = 1'b0; m_ptgt = '0; m_peret = 1'b0;
        end else if (e) begin
            if (!m_exl) begin
                m_epc = m_pc;
                m_exl = 1'b1;
            end
            m_pc   = EXC_VEC;
            m_pend = 1'b0;
        end else if (!m_pend) begin
            if (wr) begin
                if (req) m_apply(tgt, er);
                else     m_pc = pp4;
            end else if (req) begin
                m_ptgt = tgt; m_peret = er; m_pend = 1'b1;
            end
        end else if (wr) begin
            m_apply(m_ptgt, m_peret);
            m_pend = 1'b0;
        end
        x.pc = m_pc; x.epc = m_epc; x.exl = m_exl; x.pend = m_pend; x.mis = m_mis;
        sb.push_back(x);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("pc", bus.pc, got.pc);
        check("pc_plus4", bus.pc_plus4, got.pc + 32'd4);
        check("epc", bus.epc, got.epc);
        check("exl", 32'(bus.exl), 32'(got.exl));
        check("redirect_pending", 32'(bus.redirect_pending), 32'(got.pend));
`ifdef PC_ALIGN_CHECK_EN
        check("misalign", 32'(bus.misalign), 32'(got.mis));
`endif
    endtask

    task automatic idle(input logic wr);
        cyc(1'b0, wr, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        m_pc = '0; m_epc = '0; m_ptgt = '0; m_exl = 1'b0; m_pend = 1'b0; m_peret = 1'b0; m_mis = 1'b0;
        rst = 1'b1;
        bus.pc_wr = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0; bus.jump = 1'b0;
        bus.jump_idx = '0; bus.jr = 1'b0; bus.jr_target = '0; bus.exc = 1'b0; bus.eret = 1'b0;

        // Reset and sequential fetch
        do_reset();
        check("tp_reset_pc", bus.pc, 32'h3000);
        check("tp_reset_exl", 32'(bus.exl), 32'd0);
        idle(1'b1); check("tp_seq1", bus.pc, 32'h3004);
        idle(1'b1); check("tp_seq2", bus.pc, 32'h3008);
        idle(1'b1); check("tp_seq3", bus.pc, 32'h300C);
        idle(1'b1);

        // Branch beats jump, then J-type target formation
        cyc(1'b0, 1'b1, 1'b1, 32'h3040, 1'b1, 26'h0000C10, 1'b0, '0, 1'b0, 1'b0);
        check("tp_br_wins", bus.pc, 32'h3040);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 26'h0000C10, 1'b0, '0, 1'b0, 1'b0);
        check("tp_jump", bus.pc, 32'h3040);

        // Redirect during stall buffered, later requests dropped
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3100, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("tp_stall_hold", bus.pc, 32'h3040);
        check("tp_pending", 32'(bus.redirect_pending), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'h3200, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("tp_pend_apply", bus.pc, 32'h3100);

        // Exception over pending redirect, nested exception, eret
        do_reset();
        repeat (8) idle(1'b1);
        check("tp_pc_3020", bus.pc, 32'h3020);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3100, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("tp_exc_pc", bus.pc, 32'h4180);
        check("tp_exc_epc", bus.epc, 32'h3020);
        idle(1'b1);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("tp_nested_epc", bus.epc, 32'h3020);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3300, 1'b0, 1'b1);
        check("tp_eret_pc", bus.pc, 32'h3020);
        check("tp_eret_exl", 32'(bus.exl), 32'd0);

        // Buffered eret clears exl when applied
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("tp_beret_exl_held", 32'(bus.exl), 32'd1);
        idle(1'b1);
        check("tp_beret_exl_clr", 32'(bus.exl), 32'd0);

        // Reset mid-stall discards buffered redirect
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3500, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("tp_rst_stall_pend", 32'(bus.redirect_pending), 32'd0);
        idle(1'b1);
        check("tp_rst_stall_pc", bus.pc, 32'h3004);

        // pc_plus4 wrap
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("tp_wrap_p4", bus.pc_plus4, 32'h0);
        idle(1'b1);
        check("tp_wrap_pc", bus.pc, 32'h0);

        // Misaligned register-jump target
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3102, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("tp_mis_pc", bus.pc, 32'h4180);
        check("tp_mis_epc", bus.epc, 32'h3102);
        check("tp_mis_pulse", 32'(bus.misalign), 32'd1);
        idle(1'b1);
        check("tp_mis_pulse_end", 32'(bus.misalign), 32'd0);
`else
        check("tp_mis_pc", bus.pc, 32'h3102);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            b = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) b[1] = 1'b1;
            cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 4) == 0), a, ($urandom_range(0, 4) == 0),
                26'($urandom), ($urandom_range(0, 5) == 0), b,
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 10) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
